// File: rtl/subtractor_operand_loader.sv
// Operand loader for the 4-bit ones'-complement subtractor: synchronizes the
// board switches and buttons, debounces LOAD/CLEAR, and captures A then B on
// successive LOAD presses, flagging valid once a complete pair is held.

// Per-button conditioning: 2-flop synchronizer, debouncer, rising-edge pulse.
module subtractor_operand_loader_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             lvl_q, lvl_d;
  logic             lvl_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Debounce counter: runs only while the synchronized input disagrees with
  // the accepted level; the level flips once the disagreement has lasted
  // DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = lvl_q & ~lvl_prev_q;
    if (sync_q != lvl_q) begin
      if (cnt_q == CNT_MAX) begin
        lvl_d = ~lvl_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, accepted level, counter and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      meta_q     <= btn_i;
      sync_q     <= meta_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// Top level: operand capture FSM driving the subtractor A/B inputs.
module subtractor_operand_loader #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_sync_q;
  logic             load_p;
  logic             clear_p;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  // Two-flop synchronizer for the slide switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  subtractor_operand_loader_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_load),
    .press_o(load_p)
  );

  subtractor_operand_loader_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_clear),
    .press_o(clear_p)
  );

  // Next-state and operand capture; clear overrides a coincident load, and
  // the unused encoding recovers exactly like a clear.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (clear_p) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (load_p) begin
            a_d     = sw_sync_q;
            state_d = S_B;
          end
        end
        S_B: begin
          if (load_p) begin
            b_d     = sw_sync_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          // New pair starts; B keeps its old value until overwritten.
          if (load_p) begin
            a_d     = sw_sync_q;
            valid_d = 1'b0;
            state_d = S_B;
          end
        end
        default: begin
          state_d = S_A;
          a_d     = '0;
          b_d     = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign valid = valid_q;
  assign state = state_q;

endmodule

// File: tb/tb_subtractor_operand_loader.sv
// Directed bench for subtractor_operand_loader with DEBOUNCE_CYCLES = 4.
module tb_subtractor_operand_loader;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw;
  logic             btn_load;
  logic             btn_clear;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             valid;
  logic [1:0]       state;

  int n_checks = 0;
  int n_fail   = 0;

  subtractor_operand_loader #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clear(btn_clear),
    .A        (A),
    .B        (B),
    .valid    (valid),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ev, input logic [1:0] es);
    check({tag, "_A"},     32'(A),     32'(ea));
    check({tag, "_B"},     32'(B),     32'(eb));
    check({tag, "_valid"}, 32'(valid), 32'(ev));
    check({tag, "_state"}, 32'(state), 32'(es));
  endtask

  task automatic press_load(input logic [3:0] v, input int hi, input int lo);
    sw       = v;
    btn_load = 1'b1;
    tick(hi);
    btn_load = 1'b0;
    tick(lo);
  endtask

  task automatic press_clear(input int hi, input int lo);
    btn_clear = 1'b1;
    tick(hi);
    btn_clear = 1'b0;
    tick(lo);
  endtask

  int bounce [7] = '{1, 1, 0, 1, 1, 1, 0};

  initial begin
    rst_n     = 1'b0;
    sw        = '0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    tick(3);
    check_out("reset", 4'h0, 4'h0, 1'b0, 2'b00);
    rst_n = 1'b1;
    tick(2);

    // Switch activity without presses never reaches the outputs.
    for (int i = 0; i < 12; i++) begin
      sw = 4'(i * 5);
      tick(1);
    end
    check_out("sw_idle", 4'h0, 4'h0, 1'b0, 2'b00);

    // First press: pulse after edge DEB+3, capture on edge DEB+4.
    sw       = 4'b0110;
    btn_load = 1'b1;
    tick(DEB + 3);
    check("lat_before_A", 32'(A), 32'h0);
    check("lat_before_state", 32'(state), 32'h0);
    tick(1);
    check("lat_at_A", 32'(A), 32'h6);
    check("lat_at_state", 32'(state), 32'h1);
    tick(10 - (DEB + 4));
    btn_load = 1'b0;
    tick(10);
    check_out("load_A", 4'h6, 4'h0, 1'b0, 2'b01);

    press_load(4'b0011, 10, 10);
    check_out("load_B", 4'h6, 4'h3, 1'b1, 2'b10);

    sw = 4'hF;
    tick(8);
    check_out("hold_sw", 4'h6, 4'h3, 1'b1, 2'b10);

    // Reload from S_HOLD starts a new pair.
    press_load(4'b1001, 10, 10);
    check_out("reload_A", 4'h9, 4'h3, 1'b0, 2'b01);
    press_load(4'b0001, 10, 10);
    check_out("reload_B", 4'h9, 4'h1, 1'b1, 2'b10);

    // Clear from S_B.
    press_load(4'b0101, 10, 10);
    check_out("pre_clear", 4'h5, 4'h1, 1'b0, 2'b01);
    press_clear(10, 10);
    check_out("clear_sb", 4'h0, 4'h0, 1'b0, 2'b00);

    // Bounce shorter than the window, then a stable press: one capture.
    sw = 4'b1010;
    foreach (bounce[i]) begin
      btn_load = bounce[i][0];
      tick(1);
    end
    tick(6);
    check("bounce_mid_state", 32'(state), 32'h0);
    btn_load = 1'b1;
    tick(12);
    btn_load = 1'b0;
    tick(10);
    check_out("bounce", 4'hA, 4'h0, 1'b0, 2'b01);

    // Long hold captures once only.
    press_clear(10, 10);
    check_out("clear_again", 4'h0, 4'h0, 1'b0, 2'b00);
    press_load(4'b1100, 50, 10);
    check_out("held", 4'hC, 4'h0, 1'b0, 2'b01);

    // Coincident load and clear pulses: clear wins.
    sw        = 4'b0111;
    btn_load  = 1'b1;
    btn_clear = 1'b1;
    tick(12);
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    tick(10);
    check_out("coincide", 4'h0, 4'h0, 1'b0, 2'b00);

    // Reset in the middle of a debounce window.
    press_load(4'b1110, 10, 10);
    check_out("pre_rst", 4'hE, 4'h0, 1'b0, 2'b01);
    sw       = 4'b1101;
    btn_load = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 4'h0, 4'h0, 1'b0, 2'b00);
    tick(2);
    btn_load = 1'b0;
    rst_n    = 1'b1;
    tick(20);
    check_out("rst_no_late", 4'h0, 4'h0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
